rover_cpu_ocimem_arbiter: RTL and testbench

ROVER_CPU_OCIMEM_ARBITER -- requirements
Module: rover_cpu_ocimem_arbiter

---
 rtl/rover_ocimem_pkg.sv | 11 +
 rtl/rover_ocimem_jtag_pending.sv | 72 +++++++
 rtl/rover_cpu_ocimem_arbiter.sv | 116 +++++++++++
 tb/tb_rover_cpu_ocimem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rover_ocimem_pkg.sv
// Shared types and jdo field positions for the CPU/JTAG debug-RAM arbiter.
package rover_ocimem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;
  typedef enum logic {OWN_CPU, OWN_JTAG} owner_e;

  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_ADDR_LSB = 10;
  localparam int unsigned JDO_DATA_LSB = 3;

endpackage

// File: rtl/rover_ocimem_jtag_pending.sv
// JTAG side of the debug-RAM arbiter: address register, one-entry request capture,
// sticky overrun flag and monitor_ready. ROVER_OCIMEM_AUTOINC_EN enables address auto-increment.
module rover_ocimem_jtag_pending
  import rover_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              done,
  output logic              capture,
  output logic              pend_valid,
  output logic              pend_write,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_data,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  logic [ADDR_W-1:0] jtag_addr;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] access_addr;
  logic              access;
  logic              unused_jdo;

  assign load_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign access_addr = take_action_ocimem_a ? load_addr : jtag_addr;
  assign access      = take_action_ocimem_b | take_no_action_ocimem_a;
  assign capture     = access & ~pend_valid;
  assign unused_jdo  = ^jdo;

  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr     <= '0;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      monitor_ready <= 1'b0;
      jtag_overrun  <= 1'b0;
    end else begin
      if (take_action_ocimem_a) begin
        jtag_addr <= load_addr;
      end
`ifdef ROVER_OCIMEM_AUTOINC_EN
      else if (done) begin
        jtag_addr <= jtag_addr + ADDR_W'(1);
      end
`endif
      // Write wins over a coincident read; completion needs a valid entry, so it never overlaps capture.
      if (capture) begin
        pend_valid    <= 1'b1;
        pend_write    <= take_action_ocimem_b;
        pend_addr     <= access_addr;
        pend_data     <= jdo[JDO_DATA_LSB +: DATA_W];
        monitor_ready <= 1'b0;
      end else if (done) begin
        pend_valid    <= 1'b0;
        monitor_ready <= 1'b1;
      end
      if (access && pend_valid) begin
        jtag_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rover_cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing a single-port debug RAM between an Avalon-MM CPU slave
// and the JTAG debug port. ROVER_OCIMEM_AUTOINC_EN enables JTAG address auto-increment.
module rover_cpu_ocimem_arbiter
  import rover_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state, state_nxt;
  owner_e            last_owner, grant;
  logic              capture, pend_valid, pend_write;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              cpu_req, jtag_req, op_write, completing, jtag_done;
  logic              cpu_wr_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_data_q;

  rover_ocimem_jtag_pending #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pending (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .done                    (jtag_done),
    .capture                 (capture),
    .pend_valid              (pend_valid),
    .pend_write              (pend_write),
    .pend_addr               (pend_addr),
    .pend_data               (pend_data),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  // A pulse being captured this cycle already counts as pending, giving 1-cycle write latency.
  assign cpu_req    = cpu_read | cpu_write;
  assign jtag_req   = pend_valid | capture;
  assign grant      = (jtag_req && (!cpu_req || last_owner == OWN_CPU)) ? OWN_JTAG : OWN_CPU;
  assign op_write   = (last_owner == OWN_JTAG) ? pend_write : cpu_wr_q;
  assign completing = !reset && ((state == ACCESS && op_write) || state == RDWAIT);
  assign jtag_done  = completing && last_owner == OWN_JTAG;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_CPU;
      cpu_wr_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      MonDReg    <= '0;
    end else begin
      state <= state_nxt;
      // CPU request is latched at grant so a master that drops it still gets a complete RAM cycle.
      if (state == IDLE && (jtag_req || cpu_req)) begin
        last_owner <= grant;
        cpu_wr_q   <= cpu_write;
        cpu_addr_q <= cpu_address;
        cpu_data_q <= cpu_writedata;
      end
      if (jtag_done && state == RDWAIT) begin
        MonDReg <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_we       = 1'b0;
    cpu_readdata = '0;
    unique case (state)
      IDLE: begin
        if (jtag_req || cpu_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = op_write ? IDLE : RDWAIT;
        if (!reset) begin
          ram_addr = (last_owner == OWN_JTAG) ? pend_addr : cpu_addr_q;
          ram_we   = op_write;
          if (op_write) ram_wdata = (last_owner == OWN_JTAG) ? pend_data : cpu_data_q;
        end
      end
      RDWAIT: begin
        state_nxt = IDLE;
        if (!reset && last_owner == OWN_CPU) cpu_readdata = ram_rdata;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_waitrequest = cpu_req && !(completing && last_owner == OWN_CPU);

endmodule

// File: tb/tb_rover_cpu_ocimem_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized CPU/JTAG/reset traffic.
module tb_rover_cpu_ocimem_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready, jtag_overrun;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [DATA_W-1:0] cpu_writedata, cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  rover_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Single-port RAM, 1-cycle read latency
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DATA_W-1:0] ref_mem [0:255];
  bit                f_busy, f_jtag, f_wr, f_second;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  bit                p_valid, p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic [ADDR_W-1:0] m_jaddr;
  bit                m_last_jtag, m_ready, m_overrun;
  logic [DATA_W-1:0] m_mon;

  always @(posedge clk) begin : model_upd
    bit was_busy, was_pvalid, done_j, acc, creq, pick_j;
    logic [ADDR_W-1:0] na;
    if (reset) begin
      f_busy = 0; f_second = 0; p_valid = 0; m_jaddr = '0;
      m_last_jtag = 0; m_ready = 0; m_overrun = 0; m_mon = '0;
    end else begin
      was_busy = f_busy; was_pvalid = p_valid; done_j = 0;
      if (f_busy) begin
        if (f_wr) begin
          ref_mem[f_addr] = f_data; f_busy = 0; done_j = f_jtag;
        end else if (!f_second) begin
          f_second = 1;
        end else begin
          f_busy = 0; done_j = f_jtag;
          if (f_jtag) m_mon = ref_mem[f_addr];
        end
      end
      if (done_j) begin m_ready = 1; p_valid = 0; end
      na  = take_action_ocimem_a ? jdo[17:10] : m_jaddr;
      acc = take_action_ocimem_b | take_no_action_ocimem_a;
      if (acc && was_pvalid) m_overrun = 1;
      else if (acc) begin
        p_valid = 1; p_wr = take_action_ocimem_b; p_addr = na; p_data = jdo[34:3]; m_ready = 0;
      end
      if (take_action_ocimem_a) m_jaddr = na;
`ifdef ROVER_OCIMEM_AUTOINC_EN
      else if (done_j) m_jaddr = m_jaddr + 8'd1;
`endif
      creq = cpu_read | cpu_write;
      if (!was_busy && (p_valid || creq)) begin
        pick_j = p_valid && (!creq || !m_last_jtag);
        m_last_jtag = pick_j;
        f_busy = 1; f_second = 0; f_jtag = pick_j;
        if (pick_j) begin f_wr = p_wr; f_addr = p_addr; f_data = p_data; end
        else begin f_wr = cpu_write; f_addr = cpu_address; f_data = cpu_writedata; end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic              e_we, e_wait, cpu_done;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e_rd;
    if (checking) begin
      e_we = 0; e_addr = '0; e_wd = '0; e_rd = '0; cpu_done = 0;
      if (!reset && f_busy) begin
        if (!f_second) begin
          e_addr = f_addr; e_we = f_wr;
          if (f_wr) e_wd = f_data;
          if (f_wr && !f_jtag) cpu_done = 1;
        end else if (!f_jtag) begin
          e_rd = ref_mem[f_addr]; cpu_done = 1;
        end
      end
      e_wait = (cpu_read | cpu_write) && !cpu_done;
      chk("ram_we", 64'(ram_we), 64'(e_we));
      chk("ram_addr", 64'(ram_addr), 64'(e_addr));
      chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
      chk("cpu_readdata", 64'(cpu_readdata), 64'(e_rd));
      chk("cpu_waitrequest", 64'(cpu_waitrequest), 64'(e_wait));
      chk("monitor_ready", 64'(monitor_ready), 64'(m_ready));
      chk("jtag_overrun", 64'(jtag_overrun), 64'(m_overrun));
      chk("MonDReg", 64'(MonDReg), 64'(m_mon));
    end
  end

  logic [ADDR_W-1:0] we_log [$];
  always @(negedge clk) if (ram_we) we_log.push_back(ram_addr);

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk); #1;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
  endtask

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    logic [37:0] j;
    j = '0; j[17:10] = a;
    return j;
  endfunction

  task automatic do_reset();
    reset = 1; @(negedge clk); next(); reset = 0;
  endtask

  bit cpu_active, saw_done;
  logic [7:0] exp_second;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    reset = 1; jdo = '0; take_action_ocimem_a = 0; take_action_ocimem_b = 0;
    take_no_action_ocimem_a = 0; cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
    @(posedge clk); #1; checking = 1;
    @(negedge clk);
    chk("rst_monitor_ready", 64'(monitor_ready), 64'd0);
    chk("rst_overrun", 64'(jtag_overrun), 64'd0);
    chk("rst_MonDReg", 64'(MonDReg), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);

    // JTAG write then read at 0x10
    next(); reset = 0; take_action_ocimem_a = 1; jdo = jdo_addr(8'h10); @(negedge clk);
    next(); take_action_ocimem_b = 1; jdo = jdo_data(32'hDEADBEEF); @(negedge clk);
    next(); @(negedge clk);
    chk("jw_we", 64'(ram_we), 64'd1);
    chk("jw_addr", 64'(ram_addr), 64'h10);
    chk("jw_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    next(); @(negedge clk);
    chk("jw_ready", 64'(monitor_ready), 64'd1);
    next(); take_no_action_ocimem_a = 1; @(negedge clk);
    next(); @(negedge clk);
    chk("jr_addr", 64'(ram_addr), 64'h10);
    next(); @(negedge clk);
    chk("jr_mon_hold", 64'(MonDReg), 64'd0);
    next(); @(negedge clk);
    chk("jr_mon", 64'(MonDReg), 64'hDEADBEEF);
    chk("jr_ready", 64'(monitor_ready), 64'd1);

    // Tie after reset: JTAG first, then CPU read
    next(); do_reset();
    take_action_ocimem_a = 1; jdo = jdo_addr(8'h20); @(negedge clk);
    next(); take_action_ocimem_b = 1; jdo = jdo_data(32'h11112222);
    cpu_read = 1; cpu_address = 8'h10; @(negedge clk);
    chk("tie_wait", 64'(cpu_waitrequest), 64'd1);
    next(); @(negedge clk);
    chk("tie_j_addr", 64'(ram_addr), 64'h20);
    chk("tie_j_we", 64'(ram_we), 64'd1);
    next(); @(negedge clk);
    next(); @(negedge clk);
    chk("tie_c_addr", 64'(ram_addr), 64'h10);
    next(); @(negedge clk);
    chk("tie_c_wait", 64'(cpu_waitrequest), 64'd0);
    chk("tie_c_rdata", 64'(cpu_readdata), 64'hDEADBEEF);
    next(); cpu_read = 0;

    // Alternation with both continuously requesting
    do_reset();
    take_action_ocimem_a = 1; jdo = jdo_addr(8'h40); @(negedge clk);
    next(); we_log.delete();
    for (int i = 0; i < 8; i++) begin
      take_action_ocimem_b = 1; jdo = jdo_data(32'h4000 + i);
      cpu_write = 1; cpu_address = 8'h30; cpu_writedata = 32'h3000 + i;
      @(negedge clk); next();
    end
    cpu_write = 0;
    chk("alt_count", 64'(we_log.size()), 64'd4);
    if (we_log.size() == 4) begin
      chk("alt_0", 64'(we_log[0]), 64'h40);
      chk("alt_1", 64'(we_log[1]), 64'h30);
      chk("alt_2", 64'(we_log[2]), 64'h40);
      chk("alt_3", 64'(we_log[3]), 64'h30);
    end
    @(negedge clk); next(); @(negedge clk); next();

    // Overrun while CPU holds the grant; coincident load+write uses the new address
    do_reset();
    cpu_read = 1; cpu_address = 8'h10; @(negedge clk);
    next(); take_action_ocimem_a = 1; take_action_ocimem_b = 1; jdo = jdo_data(32'hAAAA2801); @(negedge clk);
    next(); take_action_ocimem_b = 1; jdo = jdo_data(32'hBBBB0002); @(negedge clk);
    next(); cpu_read = 0; @(negedge clk);
    chk("ovr_flag", 64'(jtag_overrun), 64'd1);
    next(); @(negedge clk);
    chk("ovr_we", 64'(ram_we), 64'd1);
    chk("ovr_addr", 64'(ram_addr), 64'h50);
    chk("ovr_wdata", 64'(ram_wdata), 64'hAAAA2801);
    next(); @(negedge clk);
    chk("ovr_mem", 64'(mem[8'h50]), 64'hAAAA2801);

    // Address wrap with auto-increment
`ifdef ROVER_OCIMEM_AUTOINC_EN
    exp_second = 8'h00;
`else
    exp_second = 8'hFF;
`endif
    next(); do_reset(); we_log.delete();
    take_action_ocimem_a = 1; jdo = jdo_addr(8'hFF); @(negedge clk);
    next(); take_action_ocimem_b = 1; jdo = jdo_data(32'h1); @(negedge clk);
    for (int i = 0; i < 3; i++) begin next(); @(negedge clk); end
    next(); take_action_ocimem_b = 1; jdo = jdo_data(32'h2); @(negedge clk);
    for (int i = 0; i < 3; i++) begin next(); @(negedge clk); end
    chk("inc_count", 64'(we_log.size()), 64'd2);
    if (we_log.size() == 2) begin
      chk("inc_first", 64'(we_log[0]), 64'hFF);
      chk("inc_second", 64'(we_log[1]), 64'(exp_second));
    end

    // Reset in RDWAIT of a CPU read, after a JTAG write set monitor_ready
    next(); do_reset();
    take_action_ocimem_b = 1; jdo = jdo_data(32'h5); @(negedge clk);
    next(); @(negedge clk); next(); @(negedge clk);
    chk("rr_ready_pre", 64'(monitor_ready), 64'd1);
    next(); cpu_read = 1; cpu_address = 8'h10; @(negedge clk);
    next(); @(negedge clk);
    next(); reset = 1; @(negedge clk);
    chk("rr_we", 64'(ram_we), 64'd0);
    chk("rr_rdata", 64'(cpu_readdata), 64'd0);
    chk("rr_wait_rst", 64'(cpu_waitrequest), 64'd1);
    next(); reset = 0; @(negedge clk);
    chk("rr_wait_idle", 64'(cpu_waitrequest), 64'd1);
    chk("rr_ready", 64'(monitor_ready), 64'd0);
    next(); @(negedge clk);
    chk("rr_regrant", 64'(ram_addr), 64'h10);
    next(); @(negedge clk);
    next(); cpu_read = 0;

    // Randomized traffic
    cpu_active = 0; saw_done = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset = ($urandom_range(0, 199) == 0);
      if (cpu_active && saw_done) cpu_active = 0;
      if (cpu_active && $urandom_range(0, 29) == 0) cpu_active = 0;
      if (!cpu_active && $urandom_range(0, 2) == 0) begin
        cpu_active = 1;
        if ($urandom_range(0, 1) == 1) begin cpu_read = 1; cpu_write = 0; end
        else begin cpu_read = 0; cpu_write = 1; end
        cpu_address = 8'($urandom_range(0, 15));
        cpu_writedata = $urandom;
      end
      if (!cpu_active) begin cpu_read = 0; cpu_write = 0; end
      r = $urandom_range(0, 9);
      take_action_ocimem_a = (r == 0 || r == 3);
      take_action_ocimem_b = (r == 1 || r == 3 || r == 4);
      take_no_action_ocimem_a = (r == 2 || r == 4);
      jdo = {6'($urandom), 32'($urandom)};
      jdo[17:14] = 4'h0;
      @(negedge clk);
      saw_done = (cpu_read | cpu_write) && !cpu_waitrequest;
      next();
    end
    reset = 0; cpu_read = 0; cpu_write = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); next(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
